// File: rtl/progmem_arbiter.sv
// Arbitrates the single-port program memory between instruction fetch and the loader/debug port.
// Define PMEM_STARVE_GUARD_EN to bound loader bursts (burst_cnt/owe_fetch); otherwise the loader may starve fetch.
module progmem_arbiter #(
    parameter int AW        = 14,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] fetch_addr,
    input  logic          cpu_hold,
    output logic          fetch_en,
    output logic [DW-1:0] fetch_data,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_lock,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic          pmem_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LD_ACC  = 2'd1,
        LD_ACK  = 2'd2,
        LD_IDLE = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   take;

`ifdef PMEM_STARVE_GUARD_EN
    localparam logic [7:0] MAX_B = 8'(MAX_BURST);
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       owe_fetch_q, owe_fetch_d;
`else
    logic unused_lock;
    assign unused_lock = ld_lock;
`endif

    assign fetch_data = mem_rdata;
    assign pmem_busy  = (state_q != RUN);

    always_comb begin
        state_d   = state_q;
        mem_addr  = fetch_addr;
        mem_we    = 1'b0;
        mem_wdata = ld_wdata;
        fetch_en  = 1'b0;
        ld_ack    = 1'b0;
        ld_rdata  = '0;
`ifdef PMEM_STARVE_GUARD_EN
        burst_cnt_d = burst_cnt_q;
        owe_fetch_d = owe_fetch_q;
        take        = ld_req && (!owe_fetch_q || ld_lock);
`else
        take        = ld_req;
`endif
        case (state_q)
            RUN: begin
                fetch_en = !cpu_hold && !take;
                if (take) state_d = LD_ACC;
`ifdef PMEM_STARVE_GUARD_EN
                if (fetch_en) owe_fetch_d = 1'b0;
`endif
            end
            LD_ACC: begin
                mem_addr = ld_addr;
                mem_we   = ld_we;
                state_d  = LD_ACK;
            end
            LD_ACK: begin
                mem_addr = ld_addr;
                ld_ack   = 1'b1;
                ld_rdata = mem_rdata;
                state_d  = LD_IDLE;
`ifdef PMEM_STARVE_GUARD_EN
                if (burst_cnt_q < MAX_B) burst_cnt_d = burst_cnt_q + 8'd1;
`endif
            end
            LD_IDLE: begin
`ifdef PMEM_STARVE_GUARD_EN
                if (ld_req && (ld_lock || burst_cnt_q < MAX_B)) begin
                    state_d = LD_ACC;
                end else begin
                    // Burst exhausted with a pending request: owe fetch one slot first.
                    burst_cnt_d = '0;
                    if (ld_req) owe_fetch_d = 1'b1;
                    state_d = RUN;
                end
`else
                state_d = ld_req ? LD_ACC : RUN;
`endif
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
`ifdef PMEM_STARVE_GUARD_EN
            burst_cnt_q <= '0;
            owe_fetch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef PMEM_STARVE_GUARD_EN
            burst_cnt_q <= burst_cnt_d;
            owe_fetch_q <= owe_fetch_d;
`endif
        end
    end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Scoreboard bench for progmem_arbiter: loader accesses push expected acks, a negedge monitor checks them.
module tb_progmem_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MAX_BURST = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] fetch_addr;
    logic          cpu_hold;
    logic          fetch_en;
    logic [DW-1:0] fetch_data;
    logic          ld_req, ld_we, ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_ack;
    logic [DW-1:0] ld_rdata;
    logic          pmem_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int fetch_cnt = 0;
    logic [AW-1:0] pc;

    typedef struct {
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    progmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .cpu_hold(cpu_hold),
        .fetch_en(fetch_en), .fetch_data(fetch_data), .ld_req(ld_req), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock), .ld_ack(ld_ack),
        .ld_rdata(ld_rdata), .pmem_busy(pmem_busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous-read RAM model and fetch PC model
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        if (!rst) pc <= '0;
        else if (fetch_en) pc <= pc + 1'b1;
        if (fetch_en) fetch_cnt <= fetch_cnt + 1;
    end
    always_comb fetch_addr = pc + 1'b1;

    // Monitor: every ack must match the oldest pending access
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (ld_ack === 1'b1) begin
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ld_ack=1 ld_rdata=%h, required no ack", ld_rdata);
            end else begin
                e = sbq.pop_front();
                if (e.rd && ld_rdata !== e.data) begin
                    errors++;
                    $display("FAIL ack_rdata: got %h required %h", ld_rdata, e.data);
                end
            end
        end else if (ld_ack !== 1'b0 || ld_rdata !== '0) begin
            errors++;
            $display("FAIL idle_ack: ld_ack=%b ld_rdata=%h, required 0/0", ld_ack, ld_rdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one access, wait for its ack, return at posedge+1 in LD_IDLE
    task automatic access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit last, input int exp_lat, input string name);
        exp_t e;
        int n;
        ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
        e.rd = !we; e.data = d;
        sbq.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ld_ack !== 1'b1 && n < 20);
        if (ld_ack !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no ld_ack after %0d cycles, required ack", name, n);
        end else if (exp_lat > 0) begin
            check(name, n, exp_lat);
        end
        @(posedge clk); #1;
        if (last) ld_req = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        rst = 1'b0; cpu_hold = 1'b0; ld_lock = 1'b0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 14'h0010; ld_wdata = 32'hDEADBEEF;

        repeat (3) begin
            @(negedge clk);
            check("rst_mem_we", mem_we, 0);
            check("rst_busy", pmem_busy, 0);
            check("rst_fetch_en", fetch_en, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // Write then read back, no fetch during loader ownership
        f0 = fetch_cnt;
        access(1'b1, 14'h0010, 32'hDEADBEEF, 1'b0, 3, "wr_lat");
        access(1'b0, 14'h0010, 32'hDEADBEEF, 1'b1, 3, "rd_lat");
        check("wr_rd_no_fetch", fetch_cnt - f0, 0);

        @(negedge clk);
        check("post_ld_idle_busy", pmem_busy, 1);
        @(negedge clk);
        check("run_fetch_en", fetch_en, 1);
        check("run_busy", pmem_busy, 0);
        f0 = fetch_cnt;
        repeat (3) @(negedge clk);
        check("run_rate", fetch_cnt - f0, 3);
        @(posedge clk); #1;
        cpu_hold = 1'b1;
        @(negedge clk);
        check("hold_fetch_en", fetch_en, 0);
        @(posedge clk); #1;
        cpu_hold = 1'b0;

        // Burst of 10 writes with ld_req held
        f0 = fetch_cnt;
        for (int i = 0; i < 10; i++) begin
`ifdef PMEM_STARVE_GUARD_EN
            access(1'b1, 14'(14'h0100 + i), 32'hB000_0000 + i, i == 9, (i == 8) ? 5 : 3, "burst_lat");
`else
            access(1'b1, 14'(14'h0100 + i), 32'hB000_0000 + i, i == 9, 3, "burst_lat");
`endif
        end
`ifdef PMEM_STARVE_GUARD_EN
        check("burst_fetch_slots", fetch_cnt - f0, 1);
`else
        check("burst_fetch_slots", fetch_cnt - f0, 0);
`endif
        idle(2);
        access(1'b0, 14'h0108, 32'hB000_0008, 1'b1, 3, "burst_rd_lat");
        idle(2);

        // Locked loader: 20 back-to-back writes, no fetch slot
        ld_lock = 1'b1;
        f0 = fetch_cnt;
        for (int i = 0; i < 20; i++)
            access(1'b1, 14'(14'h0200 + i), 32'hC000_0000 + i, i == 19, 3, "lock_lat");
        check("lock_no_fetch", fetch_cnt - f0, 0);
        @(negedge clk);
        check("unlock_idle_busy", pmem_busy, 1);
        @(negedge clk);
        check("unlock_run_fetch_en", fetch_en, 1);
        check("unlock_run_busy", pmem_busy, 0);
        ld_lock = 1'b0;
        idle(1);
        access(1'b0, 14'h0213, 32'hC000_0013, 1'b1, 3, "lock_rd_lat");
        idle(2);

`ifdef PMEM_STARVE_GUARD_EN
        // Guard trips while cpu_hold blocks fetch
        for (int i = 0; i < 8; i++)
            access(1'b1, 14'(14'h0300 + i), 32'hD000_0000 + i, 1'b0, 3, "owe_burst_lat");
        begin
            exp_t e;
            cpu_hold = 1'b1;
            ld_we = 1'b1; ld_addr = 14'h0308; ld_wdata = 32'hD000_0008;
            e.rd = 1'b0; e.data = 32'hD000_0008;
            sbq.push_back(e);
        end
        @(negedge clk);
        check("owe_idle_busy", pmem_busy, 1);
        repeat (5) begin
            @(negedge clk);
            check("owe_blocked_busy", pmem_busy, 0);
            check("owe_blocked_fetch_en", fetch_en, 0);
        end
        @(posedge clk); #1;
        cpu_hold = 1'b0;
        @(negedge clk);
        check("owe_fetch_en", fetch_en, 1);
        @(negedge clk);
        check("owe_take_fetch_en", fetch_en, 0);
        check("owe_take_busy", pmem_busy, 0);
        @(negedge clk);
        check("owe_acc_busy", pmem_busy, 1);
        @(negedge clk);
        check("owe_ack", ld_ack, 1);
        @(posedge clk); #1;
        ld_req = 1'b0;
        idle(2);
`endif

        // Reset asserted while a write sits in LD_ACC
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 14'h0003; ld_wdata = 32'h12345678;
        @(posedge clk); #1;
        rst = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        check("mid_acc_busy", pmem_busy, 1);
        check("mid_acc_we", mem_we, 1);
        @(negedge clk);
        check("mid_rst_busy", pmem_busy, 0);
        check("mid_rst_mem", mem[3], 32'h12345678);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        access(1'b0, 14'h0003, 32'h12345678, 1'b1, 3, "mid_rd_lat");

        idle(3);
        check("sb_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/progmem_arbiter.md
# progmem_arbiter

Shares the single-port, synchronous-read program memory between the fetch stage and the program loader/debug port. It also drives the fetch stage's `en` so fetch stalls while the loader owns the port. The block sits between the pipeline front end and the program RAM. It supports in-system program download and read-back, and bounds how long the loader can starve instruction fetch.

## Interface
Parameters:
- `AW`, 14: program memory word-address width.
- `DW`, 32: instruction word width.
- `MAX_BURST`, 8: consecutive unlocked loader accesses before a forced fetch slot (range 1..255).

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: reset, synchronous and active-low.
- `fetch_addr`  in  AW: next-word address from fetch stage (PC+1).
- `cpu_hold`  in  1: pipeline stall request; suppresses `fetch_en`.
- `fetch_en`  out  1: enable to fetch stage; PC advances and opcode is valid when high.
- `fetch_data`  out  DW: `mem_rdata`, passed through.
- `ld_req`  in  1: loader access request; held stable until `ld_ack`.
- `ld_we`  in  1: 1 = write, 0 = read.
- `ld_addr`  in  AW: loader word address.
- `ld_wdata`  in  DW: loader write data.
- `ld_lock`  in  1: loader keeps the port indefinitely, bypassing the burst limit.
- `ld_ack`  out  1: one-cycle completion pulse.
- `ld_rdata`  out  DW: read data; valid only while `ld_ack` is high, otherwise 0.
- `pmem_busy`  out  1: loader owns the port (state ≠ RUN).
- `mem_addr`  out  AW: memory address.
- `mem_we`  out  1: memory write enable.
- `mem_wdata`  out  DW: memory write data.
- `mem_rdata`  in  DW: memory read data, registered, 1-cycle latency.

## Operation
States: RUN, LD_ACC, LD_ACK, LD_IDLE.

- **RUN**
  - Drives `mem_addr=fetch_addr`, `mem_we=0`.
  - `fetch_en = !cpu_hold && !take`.
  - `take = ld_req && (!owe_fetch || ld_lock)`.
  - If `take`, go to LD_ACC. Otherwise stay in RUN.
- **LD_ACC**
  - Drives `mem_addr=ld_addr`, `mem_we=ld_we`, `mem_wdata=ld_wdata`, `fetch_en=0`.
  - Always goes to LD_ACK.
- **LD_ACK**
  - `ld_ack=1`, `ld_rdata=mem_rdata` (holds write-back data for writes and is don't-care), `mem_we=0`, `fetch_en=0`.
  - Increments `burst_cnt` (saturating at MAX_BURST). Goes to LD_IDLE.
- **LD_IDLE**
  - `fetch_en=0`, `mem_we=0`. The loader presents its next request here.
  - If `ld_req && (ld_lock || burst_cnt < MAX_BURST)`, go to LD_ACC.
  - Else if `ld_req`, set `owe_fetch`, clear `burst_cnt`, go to RUN.
  - Else clear `burst_cnt`, go to RUN.
- **owe_fetch:** cleared by any RUN cycle with `fetch_en=1`. If `cpu_hold` keeps `fetch_en` low, the loader stays blocked unless `ld_lock` is high.
- **ld_lock:** with `ld_lock` high, `burst_cnt` still counts but never forces RUN.
- **Fetch PC:** the fetch PC advances only on `fetch_en`. After the loader releases the port, the first RUN cycle with `fetch_en=1` re-reads `fetch_addr`, so no stale opcode reaches decode (fetch masks opcode with `en`).

## Timing
- **Loader latency:** a request is accepted in the edge after RUN/LD_IDLE with `ld_req`. `ld_ack` follows 2 cycles later, so the minimum spacing of back-to-back accesses is 3 cycles.
- **Read data:** `ld_rdata` = `mem[ld_addr]` in the `ld_ack` cycle.
- **Fetch:** in RUN with no hold, one instruction per cycle; `fetch_en` is combinational.
- **Reset values:** state=RUN, `burst_cnt=0`, `owe_fetch=0`, `ld_ack=0`, `ld_rdata=0`, `pmem_busy=0`, `mem_we=0`, `fetch_en=!cpu_hold && !ld_req`.
- **Reset mid-access:** a write driven in LD_ACC during the cycle `rst` is sampled low still commits at that edge, but no `ld_ack` is issued. The loader must re-request after reset.
- **ld_req and cpu_hold together in RUN:** the loader wins; `fetch_en=0`.
- **ld_req dropped before ack:** protocol violation; the access still completes and acks.
- **Address wrap:** addresses are not checked; the memory wraps at 2^AW.

## Configuration
- **`PMEM_STARVE_GUARD_EN` defined:** the burst limit and `owe_fetch` behave as described above.
- **Not defined:** `burst_cnt` and `owe_fetch` are removed. LD_IDLE returns to LD_ACC whenever `ld_req` is high. `ld_lock` is ignored, and the loader can starve fetch indefinitely.

## Test plan
- **Reset:** hold `rst=0` 3 cycles with `ld_req=1` → `ld_ack=0`, `mem_we=0`, `pmem_busy=0`. Release → LD_ACC on the next edge.
- **Write then read:** write `0xDEADBEEF` to 0x0010, then read 0x0010 → `ld_ack` 2 cycles after each acceptance, `ld_rdata=0xDEADBEEF`. `fetch_en=0` throughout; PC unchanged.
- **Burst limit (guard on, MAX_BURST=8):** `ld_req` held through 10 writes, `cpu_hold=0` → 8 acks, then exactly one RUN cycle with `fetch_en=1`, then access 9 resumes.
- **Lock:** `ld_lock=1`, 20 writes → 20 acks, no RUN cycle. Drop `ld_req` → RUN and `fetch_en=1` the next cycle.
- **Hold plus owe:** guard trips while `cpu_hold=1` for 5 cycles → loader stays blocked all 5 cycles and is re-granted only after the first `fetch_en=1` cycle.
- **Reset mid-access:** `rst=0` in LD_ACC of a write of `0x12345678` to 0x0003 → memory holds `0x12345678`, no `ld_ack`, state=RUN.
